sn_stream_decoder: RTL
======================

// Module: sn_stream_decoder
// PURPOSE
//  Receive end of the stochastic-number (SN) link: takes a serial SN bitstream with a sample
//  strobe and converts it back to binary. Counts ones over a fixed window of N = 2**WIN_LOG2
//  valid samples. Reports the unipolar count and the bipolar value (2*count - N).
//  Results go to the downstream consumer through a valid/ready hold register.
//  Sits after the comparator/XNOR multiplier datapath or an off-chip SN source.
// PARAMETERS
//  WIN_LOG2   3   log2 of window length N (valid samples per result), range 1..8
// PORTS
//  clk            in   1             single clock, rising edge
//  rst_n          in   1             asynchronous, active-high reset (asserted when 1)
//  sn_bit_i       in   1             SN data bit, sampled only when sn_valid_i=1
//  sn_valid_i     in   1             sample strobe; 0 = no sample this cycle
//  start_i        in   1             begin window accumulation from IDLE
//  cont_i         in   1             1 = back-to-back windows; 0 = single window then IDLE
//  stop_i         in   1             abort accumulation, discard partial window
//  res_count_o    out  WIN_LOG2+1    ones count, 0..N (unsigned)
//  res_bipolar_o  out  WIN_LOG2+2    2*count - N, two's complement, -N..+N
//  res_valid_o    out  1             result held and valid
//  res_ready_i    in   1             consumer accepts result when res_valid_o & res_ready_i
//  overrun_o      out  1             sticky: an unconsumed result was overwritten
//  busy_o         out  1             1 in ACCUM
// BEHAVIOUR
//  Reset: state IDLE; internal counters 0; res_count_o=0; res_bipolar_o=0; res_valid_o=0;
//    overrun_o=0; busy_o=0. Reset mid-window discards all partial state immediately.
//  FSM: IDLE --start_i--> ACCUM. In IDLE, start_i also clears overrun_o and both counters.
//    ACCUM --final sample & !cont_i--> IDLE. ACCUM --final sample & cont_i--> ACCUM.
//    ACCUM --stop_i (no final sample that cycle)--> IDLE, partial window dropped.
//    start_i in ACCUM: ignored. sn_valid_i in IDLE: ignored.
//  Accumulate: each ACCUM cycle with sn_valid_i=1 increments samp_cnt and adds sn_bit_i to ones_cnt.
//    Cycles with sn_valid_i=0 change nothing (gaps allowed, any length).
//  Final sample: sn_valid_i=1 while samp_cnt==N-1. Result = ones_cnt + sn_bit_i, which
//    includes this bit. The result is loaded into the hold register at that edge.
//    res_valid_o=1 from the next cycle (latency 1 from final sample).
//    Both counters clear at the same edge. In cont_i mode the next valid sample starts the
//    next window; no sample is skipped.
//  Width: ones_cnt is WIN_LOG2+1 bits, so count=N is representable with no wrap.
//    samp_cnt is WIN_LOG2 bits.
//  Bipolar: res_bipolar_o = {count,1'b0} - N, computed at load time and registered with the count.
//  Handshake: res_valid_o holds with stable data until a cycle with res_ready_i=1.
//    It clears after that edge unless a new load happens on the same edge.
//    Load while res_valid_o=1 & res_ready_i=0: data overwritten, res_valid_o stays 1, overrun_o<=1.
//    Load while res_valid_o=1 & res_ready_i=1: new data, res_valid_o stays 1, no overrun.
//    res_ready_i while res_valid_o=0: no effect.
//  stop_i in the same cycle as the final sample: the result is delivered, then the FSM goes to IDLE.
//  cont_i is sampled only at the final sample.
//  overrun_o is cleared only by reset or start_i in IDLE.
// STRUCTURE
//  Package sn_pkg: state enum {SN_IDLE, SN_ACCUM}; SN_WIN_LOG2_DEF=3;
//    function sn_bipolar(count, win_log2).
//  Sub-module sn_window_counter: samp_cnt/ones_cnt with clr, inc and last outputs.
//  Top holds the FSM, hold register and overrun logic.
// TESTING (WIN_LOG2=3, N=8)
//  start, 8 valid ones, ready=1 -> valid 1 cycle after 8th sample; count=8, bipolar=+8.
//  start, 10101010 with random sn_valid_i gaps -> count=4, bipolar=0; gaps do not change the result.
//  start, cont=1, all zeros, ready=0 for 2 windows -> count=0, bipolar=-8; overrun_o=1 after 2nd load.
//  Window 1 result consumed with ready=1 on the same edge as window 2 load -> valid stays 1, overrun_o=0.
//  stop_i after 5 samples -> IDLE, no result; restart with 8 ones -> count=8, not 13.
//  Reset asserted mid-window and mid-hold -> all outputs 0 immediately; sn_valid_i in IDLE ignored.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared types and helpers for the stochastic-number stream decoder.
package sn_pkg;

    localparam int unsigned SN_WIN_LOG2_DEF = 3;
    localparam int unsigned SN_WIN_LOG2_MAX = 8;
    localparam int unsigned SN_CNT_W_MAX    = SN_WIN_LOG2_MAX + 1;
    localparam int unsigned SN_BIP_W_MAX    = SN_WIN_LOG2_MAX + 2;

    typedef enum logic [0:0] {
        SN_IDLE  = 1'b0,
        SN_ACCUM = 1'b1
    } sn_state_e;

    // Bipolar mapping 2*count - 2**win_log2, two's complement at max width.
    function automatic logic [SN_BIP_W_MAX-1:0] sn_bipolar(
        input logic [SN_CNT_W_MAX-1:0] count,
        input int unsigned             win_log2
    );
        logic [SN_BIP_W_MAX-1:0] n;
        n = SN_BIP_W_MAX'(1) << win_log2;
        return {count, 1'b0} - n;
    endfunction

endpackage

// File: rtl/sn_window_counter.sv
// Sample and ones counters for one SN window; self-clears on the final sample.
module sn_window_counter
    import sn_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = SN_WIN_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    input  logic                sn_bit,
    output logic                last_c,
    output logic [WIN_LOG2:0]   ones_nxt_c
);

    localparam int unsigned N    = 1 << WIN_LOG2;
    localparam int unsigned CW   = WIN_LOG2 + 1;

    logic [WIN_LOG2-1:0] samp_cnt;
    logic [WIN_LOG2:0]   ones_cnt;

    assign last_c     = (samp_cnt == WIN_LOG2'(N - 1));
    assign ones_nxt_c = ones_cnt + CW'(sn_bit);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            samp_cnt <= '0;
            ones_cnt <= '0;
        end else if (clr) begin
            samp_cnt <= '0;
            ones_cnt <= '0;
        end else if (inc) begin
            if (last_c) begin
                samp_cnt <= '0;
                ones_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + WIN_LOG2'(1);
                ones_cnt <= ones_nxt_c;
            end
        end
    end

endmodule

// File: rtl/sn_stream_decoder.sv
// SN bitstream to binary converter: windowed ones count, bipolar value, valid/ready hold register.
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = SN_WIN_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sn_bit_i,
    input  logic                sn_valid_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                stop_i,
    output logic [WIN_LOG2:0]   res_count_o,
    output logic [WIN_LOG2+1:0] res_bipolar_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int unsigned BW = WIN_LOG2 + 2;

    sn_state_e         state;
    sn_state_e         state_nxt;
    logic              accum;
    logic              inc;
    logic              clr;
    logic              last_c;
    logic              final_smp;
    logic [WIN_LOG2:0] ones_nxt_c;

    assign accum     = (state == SN_ACCUM);
    assign inc       = accum & sn_valid_i;
    assign final_smp = inc & last_c;
    // Counters stay cleared in IDLE and drop the partial window on a stop.
    assign clr       = ~accum | (stop_i & ~final_smp);

    sn_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .inc        (inc),
        .sn_bit     (sn_bit_i),
        .last_c     (last_c),
        .ones_nxt_c (ones_nxt_c)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= SN_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SN_IDLE: begin
                if (start_i) state_nxt = SN_ACCUM;
            end
            SN_ACCUM: begin
                // A stop coinciding with the final sample still delivers, then idles.
                if (final_smp)   state_nxt = (cont_i & ~stop_i) ? SN_ACCUM : SN_IDLE;
                else if (stop_i) state_nxt = SN_IDLE;
            end
            default: state_nxt = SN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy_o        <= 1'b0;
            res_count_o   <= '0;
            res_bipolar_o <= '0;
            res_valid_o   <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            busy_o      <= (state_nxt == SN_ACCUM);
            res_valid_o <= final_smp | (res_valid_o & ~res_ready_i);
            if (final_smp) begin
                res_count_o   <= ones_nxt_c;
                res_bipolar_o <= BW'(sn_bipolar(SN_CNT_W_MAX'(ones_nxt_c), WIN_LOG2));
            end
            if (~accum & start_i)
                overrun_o <= 1'b0;
            else if (final_smp & res_valid_o & ~res_ready_i)
                overrun_o <= 1'b1;
        end
    end

endmodule
